serial_frame_loader: RTL

Serial-to-parallel front end that assembles a WIDTH-bit word from a bit-serial stream with odd parity and drives the `d`/`load` inputs of the downstream `Register` stage. It sits directly upstream of that register: on each good frame it presents the word on `d` and pulses `load` for exactly one cycle. Bad-parity frames are dropped and flagged. `d` is never disturbed by a bad or aborted frame.

---
 rtl/serial_frame_loader.sv | 82 ++++++++
 1 files changed

// File: rtl/serial_frame_loader.sv
// Bit-serial, odd-parity word loader feeding a downstream load-enabled register.
// Good frames update d and pulse load; bad or aborted frames leave d untouched.
module serial_frame_loader #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [WIDTH-1:0] d,
    output logic             load,
    output logic             busy,
    output logic             parity_err
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;

    state_e           state;
    logic [WIDTH-1:0] shreg;
    logic [CntW-1:0]  cnt;
    logic             par;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= StIdle;
            shreg      <= '0;
            cnt        <= '0;
            par        <= 1'b0;
            d          <= '0;
            load       <= 1'b0;
            busy       <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            load       <= 1'b0;
            parity_err <= 1'b0;
            // start wins in every state: opens a frame or aborts the current one
            if (start) begin
                state <= StShift;
                cnt   <= '0;
                par   <= 1'b0;
                busy  <= 1'b1;
            end else begin
                unique case (state)
                    StIdle: begin
                        busy <= 1'b0;
                    end
                    StShift: begin
                        if (bit_valid) begin
                            shreg <= {shreg[WIDTH-2:0], bit_in};
                            par   <= par ^ bit_in;
                            cnt   <= cnt + 1'b1;
                            if (cnt == LastCnt) begin
                                state <= StParity;
                            end
                        end
                    end
                    StParity: begin
                        if (bit_valid) begin
                            if (par ^ bit_in) begin
                                d    <= shreg;
                                load <= 1'b1;
                            end else begin
                                parity_err <= 1'b1;
                            end
                            state <= StIdle;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
